// File: rtl/dmem_ctrl.sv
// Data-memory access controller: turns datapath load/store requests into a
// single outstanding request/acknowledge bus transaction, stalling the
// datapath until the access completes, faults on misalignment, or times out.
module dmem_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  // Wait counter is at least 5 bits, wider if TIMEOUT needs it.
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 5) ? $clog2(TIMEOUT + 1) : 5;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_we_q, bus_we_d;
  logic [31:0]      bus_addr_q, bus_addr_d;
  logic [31:0]      bus_wdata_q, bus_wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  logic valid;
  logic aligned;

  assign valid   = memread | memwrite;
  assign aligned = (addr[1:0] == 2'b00);

  // bus_req is decoded straight from the state flop so an asynchronous
  // reset drops it immediately, without waiting for a clock edge.
  assign bus_req   = (state_q == S_REQ);
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign rdata     = rdata_q;
  assign err       = err_q;

  // Next-state, bus-field, load-data and fault computation; stall is combinational.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    stall       = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall = valid & aligned;
        if (valid) begin
          if (aligned) begin
            state_d     = S_REQ;
            cnt_d       = '0;
            bus_addr_d  = {addr[31:2], 2'b00};
            bus_we_d    = memwrite;
            bus_wdata_d = wdata;
          end else begin
            // Misaligned: no bus cycle, flag the fault, zero a load result.
            err_d = 1'b1;
            if (!memwrite) rdata_d = 32'h0;
          end
        end
      end
      S_REQ: begin
        stall = 1'b1;
        if (bus_ack) begin
          state_d = S_DONE;
          if (!bus_we_q) rdata_d = bus_rdata;
        end else if (cnt_q == CNT_LAST) begin
          // This cycle is the TIMEOUT-th without an ack: abort the access.
          state_d = S_DONE;
          err_d   = 1'b1;
          if (!bus_we_q) rdata_d = 32'h0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        // One release cycle; always back to IDLE so a held request is not reissued.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_wdata_q <= 32'h0;
      rdata_q     <= 32'h0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Testbench for dmem_ctrl: per-cycle vector table plus hand-written
// sequences for reset, timeout and reset during an outstanding access.
module tb_dmem_ctrl;

  logic        clk;
  logic        rst_n;
  logic        memread, memwrite;
  logic [31:0] addr, wdata, rdata;
  logic        stall, err, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_ack;

  int checks = 0;
  int errors = 0;

  dmem_ctrl #(.TIMEOUT(16)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .memread   (memread),
    .memwrite  (memwrite),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .stall     (stall),
    .err       (err),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd, wr;
    logic [31:0] a, wd;
    logic        ack;
    logic [31:0] brd;
    logic        e_stall, e_req, e_we;
    logic [31:0] e_baddr, e_bwdata, e_rdata;
    logic        e_err;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic ack, input logic [31:0] brd);
    memread   = rd;
    memwrite  = wr;
    addr      = a;
    wdata     = wd;
    bus_ack   = ack;
    bus_rdata = brd;
  endtask

  task automatic add(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                     input logic ack, input logic [31:0] brd,
                     input logic s, input logic rq, input logic we, input logic [31:0] ba,
                     input logic [31:0] bw, input logic [31:0] rdv, input logic e);
    vec_t v;
    v.rd = rd; v.wr = wr; v.a = a; v.wd = wd; v.ack = ack; v.brd = brd;
    v.e_stall = s; v.e_req = rq; v.e_we = we; v.e_baddr = ba;
    v.e_bwdata = bw; v.e_rdata = rdv; v.e_err = e;
    vq.push_back(v);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset held with random inputs.
    rst_n = 1'b0;
    drive(1'b1, $urandom_range(0, 1) == 1, $urandom, $urandom, 1'b1, $urandom);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_bus_req",  {31'b0, bus_req}, 32'h0);
    chk("rst_rdata",    rdata,            32'h0);
    chk("rst_err",      {31'b0, err},     32'h0);
    chk("rst_bus_addr", bus_addr,         32'h0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    rst_n = 1'b1;

    //  rd wr addr          wdata         ack brd          | stall req we baddr        bwdata        rdata         err
    add(0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 0, 0, 32'h0,   32'h0,        32'h0,        0);
    // read, ack in third REQ cycle, late ack in DONE ignored
    add(1, 0, 32'h100,      32'h0,        0, 32'h0,        1, 0, 0, 32'h0,   32'h0,        32'h0,        0);
    add(1, 0, 32'h100,      32'h0,        0, 32'h0,        1, 1, 0, 32'h100, 32'h0,        32'h0,        0);
    add(1, 0, 32'h100,      32'h0,        0, 32'h0,        1, 1, 0, 32'h100, 32'h0,        32'h0,        0);
    add(1, 0, 32'h100,      32'h0,        1, 32'h12345678, 1, 1, 0, 32'h100, 32'h0,        32'h0,        0);
    add(1, 0, 32'h100,      32'h0,        1, 32'hDEADBEEF, 0, 0, 0, 32'h100, 32'h0,        32'h12345678, 0);
    add(0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 0, 0, 32'h100, 32'h0,        32'h12345678, 0);
    // write, ack in first REQ cycle; rdata untouched
    add(0, 1, 32'h200,      32'hCAFEF00D, 0, 32'h0,        1, 0, 0, 32'h100, 32'h0,        32'h12345678, 0);
    add(0, 1, 32'h200,      32'hCAFEF00D, 1, 32'h55555555, 1, 1, 1, 32'h200, 32'hCAFEF00D, 32'h12345678, 0);
    add(0, 1, 32'h200,      32'hCAFEF00D, 0, 32'h0,        0, 0, 1, 32'h200, 32'hCAFEF00D, 32'h12345678, 0);
    add(0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 0, 1, 32'h200, 32'hCAFEF00D, 32'h12345678, 0);
    // read+write together behaves as a write
    add(1, 1, 32'h300,      32'h11112222, 0, 32'h0,        1, 0, 1, 32'h200, 32'hCAFEF00D, 32'h12345678, 0);
    add(1, 1, 32'h300,      32'h11112222, 1, 32'h99999999, 1, 1, 1, 32'h300, 32'h11112222, 32'h12345678, 0);
    add(0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 0, 1, 32'h300, 32'h11112222, 32'h12345678, 0);
    // ack in IDLE ignored
    add(0, 0, 32'h0,        32'h0,        1, 32'h77777777, 0, 0, 1, 32'h300, 32'h11112222, 32'h12345678, 0);
    // misaligned read: no request, err next cycle, rdata zeroed
    add(1, 0, 32'h103,      32'h0,        0, 32'h0,        0, 0, 1, 32'h300, 32'h11112222, 32'h12345678, 0);
    add(0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 0, 1, 32'h300, 32'h11112222, 32'h0,        1);
    add(0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 0, 1, 32'h300, 32'h11112222, 32'h0,        1);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      drive(vq[i].rd, vq[i].wr, vq[i].a, vq[i].wd, vq[i].ack, vq[i].brd);
      #1;
      chk($sformatf("v%0d_stall", i),  {31'b0, stall},   {31'b0, vq[i].e_stall});
      chk($sformatf("v%0d_req", i),    {31'b0, bus_req}, {31'b0, vq[i].e_req});
      chk($sformatf("v%0d_we", i),     {31'b0, bus_we},  {31'b0, vq[i].e_we});
      chk($sformatf("v%0d_baddr", i),  bus_addr,         vq[i].e_baddr);
      chk($sformatf("v%0d_bwdata", i), bus_wdata,        vq[i].e_bwdata);
      chk($sformatf("v%0d_rdata", i),  rdata,            vq[i].e_rdata);
      chk($sformatf("v%0d_err", i),    {31'b0, err},     {31'b0, vq[i].e_err});
    end

    // Timeout: load rdata with a known value first, then a read never acked.
    reset_pulse();
    drive(1'b1, 1'b0, 32'h400, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h400, 32'h0, 1'b1, 32'hA5A5A5A5);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    #1;
    chk("to_pre_rdata", rdata, 32'hA5A5A5A5);
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h404, 32'h0, 1'b0, 32'h0);
    #1;
    chk("to_req_stall", {31'b0, stall}, 32'h1);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("to_busreq_c%0d", i), {31'b0, bus_req}, 32'h1);
      chk($sformatf("to_stall_c%0d", i),  {31'b0, stall},   32'h1);
    end
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h404, 32'h0, 1'b1, 32'hFFFFFFFF);
    #1;
    chk("to_done_req",   {31'b0, bus_req}, 32'h0);
    chk("to_done_stall", {31'b0, stall},   32'h0);
    chk("to_done_err",   {31'b0, err},     32'h1);
    chk("to_done_rdata", rdata,            32'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    #1;
    chk("to_late_rdata", rdata,            32'h0);
    chk("to_late_req",   {31'b0, bus_req}, 32'h0);
    chk("to_late_err",   {31'b0, err},     32'h1);

    // Reset asserted two cycles into REQ.
    reset_pulse();
    drive(1'b1, 1'b0, 32'h500, 32'h0, 1'b0, 32'h0);
    #1;
    chk("rm_stall_n", {31'b0, stall}, 32'h1);
    @(negedge clk);
    #1;
    chk("rm_req_1", {31'b0, bus_req}, 32'h1);
    @(negedge clk);
    #1;
    chk("rm_req_2", {31'b0, bus_req}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rm_req_async",  {31'b0, bus_req}, 32'h0);
    chk("rm_baddr_rst",  bus_addr,         32'h0);
    chk("rm_stall_comb", {31'b0, stall},   32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 32'h600, 32'h0, 1'b0, 32'h0);
    #1;
    chk("rm_new_stall", {31'b0, stall},   32'h1);
    chk("rm_new_req0",  {31'b0, bus_req}, 32'h0);
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h600, 32'h0, 1'b1, 32'h0BADCAFE);
    #1;
    chk("rm_new_req1",  {31'b0, bus_req}, 32'h1);
    chk("rm_new_baddr", bus_addr,         32'h600);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    #1;
    chk("rm_done_stall", {31'b0, stall}, 32'h0);
    chk("rm_done_rdata", rdata,          32'h0BADCAFE);
    chk("rm_done_err",   {31'b0, err},   32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum number of cycles bus_req waits for bus_ack before the access is aborted.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 memread  input  1  datapath load request; held stable while stall=1.
REQ-005 memwrite  input  1  datapath store request; held stable while stall=1.
REQ-006 addr  input  32  byte address from the datapath ALU result.
REQ-007 wdata  input  32  store data from the datapath register file.
REQ-008 rdata  output  32  load data returned to the datapath result mux.
REQ-009 stall  output  1  freeze request to the datapath PC and register file.
REQ-010 err  output  1  sticky fault flag for misaligned access or timeout.
REQ-011 bus_req  output  1  external memory request, held high until acknowledged.
REQ-012 bus_we  output  1  external write enable; 1 = write, 0 = read.
REQ-013 bus_addr  output  32  external word address (byte address, bits [1:0] = 0).
REQ-014 bus_wdata  output  32  external write data.
REQ-015 bus_rdata  input  32  external read data, valid in the cycle bus_ack=1.
REQ-016 bus_ack  input  1  external completion strobe, one cycle wide.

Function
REQ-017 The controller SHALL implement three states:
- IDLE: no access in progress.
- REQ: bus access outstanding.
- DONE: one-cycle release of the datapath.
REQ-018 An access SHALL be valid when (memread|memwrite)=1 in IDLE.
REQ-019 A valid access SHALL be aligned when addr[1:0]=2'b00.
REQ-020 When memread and memwrite are both 1, the access SHALL be treated as a write, with no error.
REQ-021 In IDLE, stall SHALL equal valid & aligned, combinationally in the same cycle the request appears.
REQ-022 On a valid aligned access, IDLE SHALL go to REQ and register the bus fields for the next cycle:
- bus_addr = addr
- bus_we = memwrite
- bus_wdata = wdata
REQ-023 In REQ, bus_req SHALL be 1 and bus_addr/bus_we/bus_wdata SHALL stay stable; stall SHALL be 1.
REQ-024 In REQ with bus_ack=1, the controller SHALL go to DONE; for a read, rdata SHALL capture bus_rdata at that edge.
REQ-025 Minimum latency: request in cycle N, bus_req in N+1; if bus_ack arrives in N+1, DONE is in N+2, giving 2 stall cycles.
REQ-026 In DONE, stall SHALL be 0 and bus_req SHALL be 0; the next state SHALL always be IDLE, so a held request is never reissued.
REQ-027 A 5-bit (or wider) wait counter SHALL clear on entry to REQ and increment each REQ cycle without bus_ack.
REQ-028 When the wait counter reaches TIMEOUT with no ack, the controller SHALL:
- drop bus_req,
- set err,
- go to DONE,
- load rdata with 32'h0 if the access was a read.
REQ-029 A misaligned valid access SHALL make no bus request, set err, keep stall=0 and, for a read, load rdata with 32'h0; the state SHALL remain IDLE.
REQ-030 bus_ack SHALL be ignored in IDLE and DONE (a late ack has no effect).
REQ-031 rdata SHALL hold its value between reads; writes SHALL NOT modify rdata.
REQ-032 err SHALL be sticky, cleared only by reset.

Reset
REQ-033 While reset=0, the following SHALL be forced asynchronously:
- state = IDLE; counter = 0
- bus_req = 0, bus_we = 0, bus_addr = 0, bus_wdata = 0
- rdata = 0, err = 0
REQ-034 stall SHALL be combinational from state and inputs during reset; it is not a reset value.
REQ-035 Reset asserted during REQ SHALL abort the access; bus_req SHALL fall in the same cycle, without waiting for a clock edge.

Verification
REQ-036 Reset: reset=0 with random inputs -> bus_req=0, rdata=0, err=0, bus_addr=0.
REQ-037 Read: addr=0x100, memread=1 at cycle N, bus_ack=1 with bus_rdata=0x12345678 at N+3 -> results:
- stall=1 for N..N+3 and 0 at N+4,
- bus_req=1 for N+1..N+3,
- rdata=0x12345678 from N+4.
REQ-038 Write: addr=0x200, wdata=0xCAFEF00D, memwrite=1, bus_ack in the first REQ cycle -> results:
- bus_we=1, bus_wdata=0xCAFEF00D,
- stall high for exactly 2 cycles,
- rdata unchanged.
REQ-039 Misaligned: memread=1, addr=0x103 -> bus_req stays 0, stall=0, err=1 next cycle, rdata=0.
REQ-040 Timeout: TIMEOUT=16, memread=1, bus_ack never asserted -> results:
- bus_req high 16 cycles then 0,
- err=1, one DONE cycle with stall=0, rdata=0,
- a later bus_ack is ignored.
REQ-041 Reset mid-access: reset=0 two cycles into REQ -> bus_req=0 immediately, state IDLE; after release, a new read completes normally.
